// File: rtl/sequenciador_operacao.sv
// -----------------------------------------------------------------------------
// sequenciador_operacao
//
// Operand sequencer for the SomaMultiplica add/multiply stage. It pairs two
// words of an input stream into the stage operands (abc, xis) together with
// the operation select H. It holds the operands stable while the stage
// computes and captures the stage's registered result one cycle later. The
// result is then presented on an output valid/ready handshake. Completed
// operations are counted modulo 256.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   dado_in      input word (first = abc operand, second = xis operand)
//   op_in        operation select, sampled with the first word (1 mul, 0 add)
//   dado_valid   producer has a word on dado_in
//   dado_ready   block accepts a word this cycle
//   abc, xis     operands to the arithmetic stage
//   H            operation select to the arithmetic stage
//   resultado    registered result from the arithmetic stage
//   saida        captured result
//   saida_valid  saida holds a result awaiting the consumer
//   saida_ready  consumer accepts saida
//   contagem     completed operations, wraps modulo 256
// -----------------------------------------------------------------------------
module sequenciador_operacao #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] dado_in,
  input  logic             op_in,
  input  logic             dado_valid,
  output logic             dado_ready,
  output logic [WIDTH-1:0] abc,
  output logic [WIDTH-1:0] xis,
  output logic             H,
  input  logic [WIDTH-1:0] resultado,
  output logic [WIDTH-1:0] saida,
  output logic             saida_valid,
  input  logic             saida_ready,
  output logic [7:0]       contagem
);

  typedef enum logic [2:0] {
    ESPERA_A = 3'd0,  // waiting for the abc word
    ESPERA_B = 3'd1,  // waiting for the xis word
    EXECUTA  = 3'd2,  // operands stable, stage samples them at the end
    AGUARDA  = 3'd3,  // stage result is registered, capture it
    ENTREGA  = 3'd4   // result offered downstream
  } estado_t;

  estado_t          estado_q, estado_d;
  logic [WIDTH-1:0] abc_q, abc_d;
  logic [WIDTH-1:0] xis_q, xis_d;
  logic [WIDTH-1:0] saida_q, saida_d;
  logic             h_q, h_d;
  logic [7:0]       cont_q, cont_d;
  logic             aceita_estado;
  logic             entrega_estado;

  // Handshake flags are pure decodes of the state register. They are gated
  // with rst_n because the reset state is ESPERA_A, which would otherwise
  // report ready while the block is held in reset.
  assign aceita_estado  = (estado_q == ESPERA_A) || (estado_q == ESPERA_B);
  assign entrega_estado = (estado_q == ENTREGA);
  assign dado_ready     = rst_n & aceita_estado;
  assign saida_valid    = rst_n & entrega_estado;

  assign abc      = abc_q;
  assign xis      = xis_q;
  assign H        = h_q;
  assign saida    = saida_q;
  assign contagem = cont_q;

  always_comb begin
    // NOTE: every signal driven here gets a default first; a path that left
    // one unassigned would infer a latch.
    estado_d = estado_q;
    abc_d    = abc_q;
    xis_d    = xis_q;
    h_d      = h_q;
    saida_d  = saida_q;
    cont_d   = cont_q;

    unique case (estado_q)
      ESPERA_A: begin
        if (dado_valid) begin
          abc_d    = dado_in;
          h_d      = op_in;
          estado_d = ESPERA_B;
        end
      end
      ESPERA_B: begin
        if (dado_valid) begin
          xis_d    = dado_in;
          estado_d = EXECUTA;
        end
      end
      EXECUTA: begin
        estado_d = AGUARDA;
      end
      AGUARDA: begin
        // resultado now reflects the operands held through EXECUTA.
        saida_d  = resultado;
        cont_d   = cont_q + 8'd1;
        estado_d = ENTREGA;
      end
      ENTREGA: begin
        if (saida_ready) estado_d = ESPERA_A;
      end
      default: estado_d = ESPERA_A;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the values from before the edge, regardless of statement order.
  // NOTE: all datapath registers are reset; the outputs drive another block,
  // so they must come up at a known value rather than whatever powers up.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q <= ESPERA_A;
      abc_q    <= '0;
      xis_q    <= '0;
      h_q      <= 1'b0;
      saida_q  <= '0;
      cont_q   <= 8'd0;
    end else begin
      estado_q <= estado_d;
      abc_q    <= abc_d;
      xis_q    <= xis_d;
      h_q      <= h_d;
      saida_q  <= saida_d;
      cont_q   <= cont_d;
    end
  end

endmodule

// File: tb/tb_sequenciador_operacao.sv
// -----------------------------------------------------------------------------
// Testbench for sequenciador_operacao. It includes a behavioural model of the
// SomaMultiplica stage, which registers abc+xis or abc*xis every clock. It
// also holds a reference model of the expected results and operation count.
// -----------------------------------------------------------------------------
module tb_sequenciador_operacao;

  localparam int WIDTH = 16;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] dado_in;
  logic             op_in;
  logic             dado_valid;
  logic             dado_ready;
  logic [WIDTH-1:0] abc;
  logic [WIDTH-1:0] xis;
  logic             H;
  logic [WIDTH-1:0] resultado;
  logic [WIDTH-1:0] saida;
  logic             saida_valid;
  logic             saida_ready;
  logic [7:0]       contagem;

  int n_vec = 0;
  int n_err = 0;
  int ops_model = 0;  // completed operations since the last reset

  sequenciador_operacao #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .dado_in    (dado_in),
    .op_in      (op_in),
    .dado_valid (dado_valid),
    .dado_ready (dado_ready),
    .abc        (abc),
    .xis        (xis),
    .H          (H),
    .resultado  (resultado),
    .saida      (saida),
    .saida_valid(saida_valid),
    .saida_ready(saida_ready),
    .contagem   (contagem)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Arithmetic stage: unreset register of the selected operation.
  always @(posedge clk) resultado <= H ? abc * xis : abc + xis;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Expected stage result, truncated to the operand width.
  function automatic logic [15:0] ref_op(input longint a, input longint b, input bit op);
    longint r;
    r = op ? a * b : a + b;
    return 16'(r % 65536);
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; dado_valid = 1'b0; saida_ready = 1'b0; dado_in = '0; op_in = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ops_model = 0;
  endtask

  // Present one word and hold it until it is accepted; returns 1 ns after the
  // accepting edge.
  task automatic send_word(input logic [15:0] d, input logic op);
    int k;
    k = 0;
    @(negedge clk);
    dado_in = d; op_in = op; dado_valid = 1'b1;
    while (!dado_ready && k < 50) begin @(negedge clk); k++; end
    n_vec++;
    if (!dado_ready) begin n_err++; $display("FAIL send_timeout: dado_ready=%b required 1", dado_ready); end
    @(posedge clk); #1;
    dado_valid = 1'b0;
  endtask

  // Count falling edges until saida_valid is seen.
  task automatic wait_valid(output int lat);
    lat = 0;
    do begin @(negedge clk); lat++; end while (!saida_valid && lat < 100);
    n_vec++;
    if (!saida_valid) begin n_err++; $display("FAIL valid_timeout: saida_valid=%b required 1", saida_valid); end
  endtask

  task automatic consume();
    saida_ready = 1'b1;
    @(posedge clk); #1;
    saida_ready = 1'b0;
  endtask

  // Full operation; returns what the DUT shows during ENTREGA.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic op, input int hold,
                        output logic [15:0] res, output logic [7:0] cnt, output int lat);
    send_word(a, op);
    send_word(b, 1'b0);
    wait_valid(lat);
    res = saida; cnt = contagem;
    repeat (hold) @(negedge clk);
    consume();
    ops_model++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; dado_valid = 1'b0; saida_ready = 1'b0; dado_in = '0; op_in = 1'b0;
    #12;
    n_vec += 7;
    if (abc !== 16'd0)       begin n_err++; $display("FAIL reset_abc: got %h required 0000", abc); end
    if (xis !== 16'd0)       begin n_err++; $display("FAIL reset_xis: got %h required 0000", xis); end
    if (saida !== 16'd0)     begin n_err++; $display("FAIL reset_saida: got %h required 0000", saida); end
    if (H !== 1'b0)          begin n_err++; $display("FAIL reset_H: got %b required 0", H); end
    if (saida_valid !== 1'b0) begin n_err++; $display("FAIL reset_saida_valid: got %b required 0", saida_valid); end
    if (contagem !== 8'd0)   begin n_err++; $display("FAIL reset_contagem: got %h required 00", contagem); end
    if (dado_ready !== 1'b0) begin n_err++; $display("FAIL reset_dado_ready: got %b required 0", dado_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_vec++;
    if (dado_ready !== 1'b1) begin n_err++; $display("FAIL release_dado_ready: got %b required 1", dado_ready); end
    ops_model = 0;
  endtask

  task automatic test_basic();
    int lat;
    send_word(16'd2, 1'b1);
    n_vec += 2;
    if (abc !== 16'd2) begin n_err++; $display("FAIL basic_abc: got %h required 0002", abc); end
    if (H !== 1'b1)    begin n_err++; $display("FAIL basic_H: got %b required 1", H); end
    send_word(16'd3, 1'b0);
    n_vec++;
    if (xis !== 16'd3) begin n_err++; $display("FAIL basic_xis: got %h required 0003", xis); end
    wait_valid(lat);
    n_vec += 3;
    if (lat !== 3) begin n_err++; $display("FAIL basic_latency: got %0d falling edges required 3", lat); end
    if (saida !== ref_op(2, 3, 1'b1)) begin n_err++; $display("FAIL basic_saida: got %h required %h", saida, ref_op(2, 3, 1'b1)); end
    if (contagem !== 8'd1) begin n_err++; $display("FAIL basic_contagem: got %h required 01", contagem); end
    consume();
    ops_model++;
    n_vec++;
    if (saida_valid !== 1'b0) begin n_err++; $display("FAIL basic_handshake: saida_valid=%b required 0", saida_valid); end
  endtask

  task automatic test_wrap();
    logic [15:0] res; logic [7:0] cnt; int lat;
    run_op(16'hFFFF, 16'h0002, 1'b0, 0, res, cnt, lat);
    n_vec += 2;
    if (res !== ref_op(16'hFFFF, 2, 1'b0)) begin n_err++; $display("FAIL wrap_add: got %h required %h", res, ref_op(16'hFFFF, 2, 1'b0)); end
    if (cnt !== 8'(ops_model)) begin n_err++; $display("FAIL wrap_add_cnt: got %h required %h", cnt, 8'(ops_model)); end
    run_op(16'h0100, 16'h0100, 1'b1, 0, res, cnt, lat);
    n_vec += 2;
    if (res !== ref_op(16'h0100, 16'h0100, 1'b1)) begin n_err++; $display("FAIL wrap_mul: got %h required %h", res, ref_op(16'h0100, 16'h0100, 1'b1)); end
    if (cnt !== 8'(ops_model)) begin n_err++; $display("FAIL wrap_mul_cnt: got %h required %h", cnt, 8'(ops_model)); end
  endtask

  task automatic test_backpressure();
    int lat;
    send_word(16'd3, 1'b0);
    send_word(16'd4, 1'b0);
    wait_valid(lat);
    // A word waits on the input throughout; it must not be taken early.
    dado_in = 16'h0055; op_in = 1'b1; dado_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      n_vec += 4;
      if (saida !== 16'd7)       begin n_err++; $display("FAIL bp_saida[%0d]: got %h required 0007", i, saida); end
      if (saida_valid !== 1'b1)  begin n_err++; $display("FAIL bp_valid[%0d]: got %b required 1", i, saida_valid); end
      if (dado_ready !== 1'b0)   begin n_err++; $display("FAIL bp_ready[%0d]: got %b required 0", i, dado_ready); end
      if (abc !== 16'd3)         begin n_err++; $display("FAIL bp_abc[%0d]: got %h required 0003", i, abc); end
      @(negedge clk);
    end
    consume();
    ops_model++;
    n_vec += 3;
    if (abc !== 16'd3)        begin n_err++; $display("FAIL bp_same_cycle_word: abc=%h required 0003", abc); end
    if (saida_valid !== 1'b0) begin n_err++; $display("FAIL bp_release_valid: got %b required 0", saida_valid); end
    if (dado_ready !== 1'b1)  begin n_err++; $display("FAIL bp_release_ready: got %b required 1", dado_ready); end
    @(posedge clk); #1;
    dado_valid = 1'b0;
    n_vec += 2;
    if (abc !== 16'h0055) begin n_err++; $display("FAIL bp_next_accept_abc: got %h required 0055", abc); end
    if (H !== 1'b1)       begin n_err++; $display("FAIL bp_next_accept_H: got %b required 1", H); end
    send_word(16'd2, 1'b0);
    wait_valid(lat);
    n_vec++;
    if (saida !== ref_op(16'h55, 2, 1'b1)) begin n_err++; $display("FAIL bp_followup: got %h required %h", saida, ref_op(16'h55, 2, 1'b1)); end
    consume();
    ops_model++;
  endtask

  task automatic test_idle_b();
    int lat;
    send_word(16'd5, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_vec += 3;
      if (dado_ready !== 1'b1) begin n_err++; $display("FAIL idle_ready[%0d]: got %b required 1", i, dado_ready); end
      if (abc !== 16'd5)       begin n_err++; $display("FAIL idle_abc[%0d]: got %h required 0005", i, abc); end
      if (H !== 1'b0)          begin n_err++; $display("FAIL idle_H[%0d]: got %b required 0", i, H); end
    end
    send_word(16'd9, 1'b1);
    n_vec++;
    if (H !== 1'b0) begin n_err++; $display("FAIL idle_H_b: got %b required 0", H); end
    wait_valid(lat);
    n_vec += 2;
    if (saida !== ref_op(5, 9, 1'b0)) begin n_err++; $display("FAIL idle_saida: got %h required %h", saida, ref_op(5, 9, 1'b0)); end
    if (lat !== 3) begin n_err++; $display("FAIL idle_latency: got %0d required 3", lat); end
    consume();
    ops_model++;
  endtask

  task automatic test_reset_mid();
    logic [15:0] res; logic [7:0] cnt; int lat;
    do_reset();
    for (int i = 0; i < 3; i++) run_op(16'($urandom), 16'($urandom), 1'b0, 0, res, cnt, lat);
    send_word(16'd11, 1'b1);
    send_word(16'd12, 1'b0);
    @(posedge clk); #1;  // now in AGUARDA
    n_vec++;
    if (contagem !== 8'd3) begin n_err++; $display("FAIL mid_pre_count: got %h required 03", contagem); end
    #1 rst_n = 1'b0;
    #1;
    n_vec += 5;
    if (saida_valid !== 1'b0) begin n_err++; $display("FAIL mid_valid: got %b required 0", saida_valid); end
    if (contagem !== 8'd0)    begin n_err++; $display("FAIL mid_count: got %h required 00", contagem); end
    if (abc !== 16'd0)        begin n_err++; $display("FAIL mid_abc: got %h required 0000", abc); end
    if (xis !== 16'd0)        begin n_err++; $display("FAIL mid_xis: got %h required 0000", xis); end
    if (dado_ready !== 1'b0)  begin n_err++; $display("FAIL mid_ready: got %b required 0", dado_ready); end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    ops_model = 0;
    run_op(16'd4, 16'd4, 1'b1, 0, res, cnt, lat);
    n_vec += 2;
    if (res !== ref_op(4, 4, 1'b1)) begin n_err++; $display("FAIL mid_after_saida: got %h required %h", res, ref_op(4, 4, 1'b1)); end
    if (cnt !== 8'd1)               begin n_err++; $display("FAIL mid_after_count: got %h required 01", cnt); end
  endtask

  task automatic test_random();
    logic [15:0] a, b, res; logic [7:0] cnt; logic op; int lat;
    for (int i = 0; i < 20; i++) begin
      a = 16'($urandom); b = 16'($urandom); op = 1'($urandom);
      if (i % 4 == 0) b = 16'hFFFF;
      run_op(a, b, op, int'($urandom_range(0, 3)), res, cnt, lat);
      n_vec += 3;
      if (res !== ref_op(a, b, op)) begin n_err++; $display("FAIL rand_saida[%0d]: %h %s %h got %h required %h", i, a, op ? "*" : "+", b, res, ref_op(a, b, op)); end
      if (cnt !== 8'(ops_model))    begin n_err++; $display("FAIL rand_count[%0d]: got %h required %h", i, cnt, 8'(ops_model)); end
      if (lat !== 3)                begin n_err++; $display("FAIL rand_latency[%0d]: got %0d required 3", i, lat); end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] wa [257];
    logic [15:0] wb [257];
    logic [15:0] exp_res;
    int ops_done, widx, cyc, last_a;
    bit acc;
    do_reset();
    for (int i = 0; i < 257; i++) begin wa[i] = 16'($urandom); wb[i] = 16'($urandom); end
    ops_done = 0; widx = 0; cyc = 0; last_a = 0;
    saida_ready = 1'b1;
    @(negedge clk);
    dado_valid = 1'b1; dado_in = wa[0]; op_in = 1'b0;
    while (ops_done < 257 && cyc < 3000) begin
      acc = dado_ready && dado_valid;
      if (saida_valid) begin
        exp_res = ref_op(wa[ops_done], wb[ops_done], 1'b0);
        n_vec += 2;
        if (saida !== exp_res) begin n_err++; $display("FAIL b2b_saida[%0d]: got %h required %h", ops_done, saida, exp_res); end
        if (contagem !== 8'((ops_done + 1) % 256)) begin n_err++; $display("FAIL b2b_count[%0d]: got %h required %h", ops_done, contagem, 8'((ops_done + 1) % 256)); end
        ops_done++;
      end
      @(posedge clk);
      cyc++;
      #1;
      if (acc) begin
        if (widx % 2 == 0) begin
          if (widx > 0) begin
            n_vec++;
            if (cyc - last_a !== 5) begin n_err++; $display("FAIL b2b_period[%0d]: got %0d cycles required 5", widx / 2, cyc - last_a); end
          end
          last_a = cyc;
        end
        widx++;
        if (widx < 514) dado_in = (widx % 2 == 1) ? wb[widx / 2] : wa[widx / 2];
        else dado_valid = 1'b0;
      end
      @(negedge clk);
    end
    saida_ready = 1'b0;
    dado_valid = 1'b0;
    n_vec += 2;
    if (ops_done !== 257)  begin n_err++; $display("FAIL b2b_ops: got %0d completed required 257", ops_done); end
    if (contagem !== 8'h01) begin n_err++; $display("FAIL b2b_wrap: got %h required 01", contagem); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_idle_b();
    test_random();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sequenciador_operacao.md
# sequenciador_operacao

Operand sequencer feeding the SomaMultiplica add/multiply stage. Accepts a stream of 16-bit words over a valid/ready handshake and pairs them into (abc, xis) with an operation select H. It holds the operands stable while the stage computes, captures the stage's registered `resultado` at the correct cycle, and presents it downstream on a second valid/ready handshake. It also counts completed operations.

## Interface
- `WIDTH`, default 16: operand and result width; must match the arithmetic stage.
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `dado_in`  in  WIDTH: input word; the first word is the operand for abc, the second is the operand for xis.
- `op_in`  in  1: operation select, sampled only with the first word. 1 = multiply, 0 = add.
- `dado_valid`  in  1: producer has a word on `dado_in`.
- `dado_ready`  out  1: block accepts a word this cycle.
- `abc`  out  WIDTH: operand A to the stage.
- `xis`  out  WIDTH: operand B to the stage.
- `H`  out  1: operation select to the stage.
- `resultado`  in  WIDTH: registered result from the stage.
- `saida`  out  WIDTH: captured result.
- `saida_valid`  out  1: `saida` is valid.
- `saida_ready`  in  1: consumer accepts `saida`.
- `contagem`  out  8: number of completed operations; wraps modulo 256.

## Operation
- FSM states and transitions:
  - ESPERA_A: `dado_ready`=1. On accept (`dado_valid` & `dado_ready` at a rising edge): `abc`<=`dado_in`, `H`<=`op_in`, go to ESPERA_B.
  - ESPERA_B: `dado_ready`=1. On accept: `xis`<=`dado_in`, go to EXECUTA.
  - EXECUTA: `dado_ready`=0. Operands are stable and the stage samples them at this edge. Unconditionally go to AGUARDA.
  - AGUARDA: `dado_ready`=0. `saida`<=`resultado`, `contagem`<=`contagem`+1 (wraps FF->00). Go to ENTREGA.
  - ENTREGA: `dado_ready`=0, `saida_valid`=1. Hold `saida` until `saida_ready`=1 at an edge, then go to ESPERA_A.
- `abc`, `xis` and `H` change only on an accept. Between operations they retain their last values.
- While in ESPERA_B, the stage computes with the new `abc` and the old `xis`. This is harmless, because `resultado` is captured only in AGUARDA.
- No arithmetic is done in this block. `saida` is exactly the stage's WIDTH-bit truncated result.
- `dado_valid` with `dado_ready`=0 is ignored. The word is not consumed and the producer must hold it.
- `saida_ready` outside ENTREGA is ignored.
- `dado_ready` and `saida_valid` are decoded from the state, are glitch-free from registers, and are forced to 0 while `rst_n`=0.

## Timing
- Reset (asynchronous, immediate on `rst_n` falling):
  - state = ESPERA_A;
  - `abc`, `xis`, `saida` = 0;
  - `H`, `saida_valid` = 0;
  - `contagem` = 0.
- The first accept is possible at the first rising edge after `rst_n` rises.
- Latency: if the B word is accepted at edge t, then EXECUTA covers t..t+1 and AGUARDA covers t+1..t+2. `saida_valid` is high from just after edge t+2.
- Best-case throughput is one operation per 5 cycles (A, B, EXECUTA, AGUARDA, ENTREGA with `saida_ready` held 1).
- Back-pressure: ENTREGA may last indefinitely, and no new words are accepted meanwhile.
- Reset mid-operation in any state: the operation is abandoned, `saida_valid` drops immediately, and the result is not counted.
- A word presented in the same cycle as the ENTREGA->ESPERA_A transition is not accepted, because `dado_ready` is still 0 in that cycle. It is accepted on the next edge.
- The stage's unreset `resultado` is never sampled before a full EXECUTA cycle.

## Test plan
1. Reset, then send 2 (`op_in`=1) then 3, with `saida_ready`=1 → `abc`=2, `xis`=3, `H`=1; `saida`=6 with `saida_valid` rising 2 cycles after the B accept; `contagem`=1.
2. Send 0xFFFF (`op_in`=0) then 0x0002 → `saida`=0x0001 (wraps in the stage); then 0x0100 (`op_in`=1) then 0x0100 → `saida`=0x0000.
3. Hold `saida_ready`=0 for 10 cycles after a result of 7 → `saida`=7 and `saida_valid`=1 stay stable and `dado_ready`=0 throughout; raise `saida_ready` → one-cycle handshake, then ESPERA_A with `dado_ready`=1.
4. Insert 3 idle cycles (`dado_valid`=0) between the A and B words → the FSM waits in ESPERA_B, `abc` and `H` are unchanged, and the result is correct (5+9=14).
5. Assert `rst_n`=0 during AGUARDA with `contagem`=3 → `saida_valid`=0, `contagem`=0, `abc`=`xis`=0 immediately; after release, a new 4×4 operation gives `saida`=16 and `contagem`=1.
6. Run 257 back-to-back add operations with `saida_ready`=1 → each completes in 5 cycles; `contagem` reaches 0xFF and then wraps to 0x01.
